pad_dir_ctrl: RTL
=================

PAD_DIR_CTRL -- requirements
Module: pad_dir_ctrl

Interface
REQ-001 The block SHALL have one parameter: DEB_CYCLES, default 250000, debounce stability window in clk cycles; legal range >= 2.
REQ-002 The block SHALL have these ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset.
- sw_up, sw_left, sw_mid, sw_right, sw_down  input  1 each  raw push-buttons; active-high; asynchronous; may bounce.
- dir_ack  input  1  consumer accepts the presented direction.
- dir_valid  output  1  a direction request is pending.
- dir  output  2  requested direction: 00 up, 01 down, 10 left, 11 right.
- paused  output  1  game-pause state.
- led  output  5  one-hot debounced button indicator: bit0 down, bit1 left, bit2 mid, bit3 right, bit4 up.
REQ-003 Clocking SHALL use only clk; reset SHALL be synchronous and active-low.

Function
REQ-004 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-005 Each button SHALL have a debounced state deb_x and a counter of width clog2(DEB_CYCLES).
- Synced value equals deb_x: counter <= 0.
- Synced value differs and counter == DEB_CYCLES-1: deb_x <= synced value, counter <= 0.
- Otherwise: counter increments.
REQ-006 A press event SHALL be a one-cycle pulse when deb_x is 1 and its registered previous value is 0; releases SHALL generate no event.
REQ-007 Latency: dir_valid SHALL assert exactly DEB_CYCLES+3 rising edges after the first edge that samples a stable raw press.
REQ-008 Among simultaneous direction press events, priority SHALL be down > left > right > up; only the winner is used.
REQ-009 The FSM SHALL have three states: IDLE, PEND and PAUSE.
- IDLE: dir_valid=0, paused=0.
- PEND: dir_valid=1, paused=0.
- PAUSE: dir_valid=0, paused=1.
REQ-010 IDLE transitions:
- mid press -> PAUSE; this wins over any direction press in the same cycle, which is discarded.
- Otherwise, a direction press -> PEND, with dir <= winner.
REQ-011 PEND transitions:
- mid press -> PAUSE, and the pending request is discarded.
- Otherwise, a direction press -> stay in PEND with dir <= new winner, whether or not dir_ack is high (latest wins).
- Otherwise, dir_ack=1 -> IDLE.
REQ-012 PAUSE: direction presses and dir_ack SHALL be ignored; mid press -> IDLE.
REQ-013 dir_ack SHALL be ignored whenever dir_valid=0.
REQ-014 dir SHALL be registered and SHALL change only on a direction capture or on reset; it SHALL hold its last value in IDLE and PAUSE.
REQ-015 led SHALL be the priority one-hot of the debounced states, with priority down > left > mid > right > up; it SHALL be 00000 when no button is debounced-pressed.
REQ-016 led SHALL be decoded from registers only, with no raw or synchronizer path.

Reset
REQ-017 While reset=0 at a rising edge, the block SHALL clear the following:
- all synchronizer flops, deb_x, previous-deb flops and counters to 0;
- FSM to IDLE;
- dir to 00, dir_valid to 0, paused to 0, led to 00000.
REQ-018 Reset asserted mid-operation SHALL discard any pending request and exit PAUSE.
REQ-019 A button held through reset SHALL be treated as a new press after release of reset, with the latency given in REQ-007.

Verification (DEB_CYCLES=4)
REQ-020 Clean press: sw_left held high -> dir_valid=1, dir=10 on the 7th edge; held until dir_ack=1 -> dir_valid=0 next cycle; release -> no new event; led=00010 while held.
REQ-021 Bounce: sw_right toggling every 2 cycles for 20 cycles, then stable high -> exactly one event, dir=11, asserted 7 edges after stabilisation.
REQ-022 Simultaneous press: sw_down and sw_up rising in the same cycle -> dir=01, led=00001; releasing sw_down only -> led=10000, no new event.
REQ-023 Overwrite and ack: PEND with dir=10, sw_right pressed with no ack -> dir=11, dir_valid stays 1; then dir_ack coinciding with an up press event -> stays PEND with dir=00.
REQ-024 Pause: mid press while in PEND -> paused=1, dir_valid=0; a left press and dir_ack in PAUSE -> no change; second mid press -> paused=0, IDLE, dir unchanged.
REQ-025 Reset mid-operation: in PAUSE with sw_left held, reset=0 for 1 cycle -> all outputs 0 at the next edge; dir_valid=1, dir=10 on the 7th edge after reset is released.

Source files
------------

// File: rtl/pad_dir_ctrl.sv
// ---------------------------------------------------------------------------
// pad_dir_ctrl
//   Five-button game pad front end. Each raw push-button is synchronised,
//   debounced and edge-detected. The resulting press events drive a small
//   request FSM that presents one direction to a consumer and tracks a
//   pause state toggled by the middle button.
//
// Parameters
//   DEB_CYCLES  debounce stability window in clk cycles (>= 2)
//
// Ports
//   clk        system clock, all state on its rising edge
//   reset      synchronous, active-low reset
//   sw_up, sw_left, sw_mid, sw_right, sw_down
//              raw active-high buttons (asynchronous, may bounce)
//   dir_ack    consumer accepts the presented direction
//   dir_valid  a direction request is pending
//   dir        requested direction: 00 up, 01 down, 10 left, 11 right
//   paused     game-pause state
//   led        one-hot debounced indicator:
//              bit0 down, bit1 left, bit2 mid, bit3 right, bit4 up
// ---------------------------------------------------------------------------
module pad_dir_ctrl #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_up,
    input  logic       sw_left,
    input  logic       sw_mid,
    input  logic       sw_right,
    input  logic       sw_down,
    input  logic       dir_ack,
    output logic       dir_valid,
    output logic [1:0] dir,
    output logic       paused,
    output logic [4:0] led
);

    localparam int              CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Button index: 0 down, 1 left, 2 mid, 3 right, 4 up (same as led bits)
    localparam int B_DOWN  = 0;
    localparam int B_LEFT  = 1;
    localparam int B_MID   = 2;
    localparam int B_RIGHT = 3;
    localparam int B_UP    = 4;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    logic [4:0] sw_raw;
    logic [4:0] deb_vec;
    logic [4:0] press_vec;

    assign sw_raw = {sw_up, sw_right, sw_mid, sw_left, sw_down};

    // -----------------------------------------------------------------------
    // Per-button synchroniser, debouncer and press-edge detector
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             deb_reg;
            logic             prev_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    prev_reg  <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= sw_raw[gi];
                    sync2_reg <= sync1_reg;
                    prev_reg  <= deb_reg;
                    // The counter measures how long the synced input has
                    // continuously disagreed with the debounced value; any
                    // agreement restarts the window.
                    if (sync2_reg == deb_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        deb_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
            end

            assign deb_vec[gi]   = deb_reg;
            // Rising edge of the debounced level only; releases are silent.
            assign press_vec[gi] = deb_reg & ~prev_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Direction arbitration: down > left > right > up
    // -----------------------------------------------------------------------
    logic       dir_press;
    logic [1:0] dir_win;

    always_comb begin
        dir_press = press_vec[B_DOWN] | press_vec[B_LEFT] |
                    press_vec[B_RIGHT] | press_vec[B_UP];
        dir_win   = DIR_UP;
        if (press_vec[B_DOWN]) begin
            dir_win = DIR_DOWN;
        end else if (press_vec[B_LEFT]) begin
            dir_win = DIR_LEFT;
        end else if (press_vec[B_RIGHT]) begin
            dir_win = DIR_RIGHT;
        end
    end

    // -----------------------------------------------------------------------
    // Request / pause FSM
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] dir_reg, dir_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            dir_reg   <= DIR_UP;
        end else begin
            state_reg <= state_next;
            dir_reg   <= dir_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        case (state_reg)
            ST_IDLE: begin
                // A mid press takes precedence and swallows any direction.
                if (press_vec[B_MID]) begin
                    state_next = ST_PAUSE;
                end else if (dir_press) begin
                    state_next = ST_PEND;
                    dir_next   = dir_win;
                end
            end
            ST_PEND: begin
                if (press_vec[B_MID]) begin
                    state_next = ST_PAUSE;
                end else if (dir_press) begin
                    // Newest press replaces the pending one even if the
                    // consumer acknowledges in the same cycle.
                    dir_next = dir_win;
                end else if (dir_ack) begin
                    state_next = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                if (press_vec[B_MID]) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign dir_valid = (state_reg == ST_PEND);
    assign paused    = (state_reg == ST_PAUSE);
    assign dir       = dir_reg;

    // -----------------------------------------------------------------------
    // LED: one-hot of the highest-priority debounced button (bit0 highest).
    // Loop runs low-priority first so the highest-priority hit lands last.
    // -----------------------------------------------------------------------
    always_comb begin
        led = '0;
        for (int i = 4; i >= 0; i--) begin
            if (deb_vec[i]) begin
                led    = '0;
                led[i] = 1'b1;
            end
        end
    end

endmodule
